// File: rtl/lut_search_pkg.sv
// Shared types and constants for the interpolation-table search controller.
package lut_search_pkg;

    localparam int LUT_DATA_W = 14;
    localparam int LUT_ADDR_W = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPARE,
        S_INTERP,
        S_RESP
    } lut_state_t;

    localparam logic [1:0] ST_EXACT  = 2'b00;
    localparam logic [1:0] ST_INTERP = 2'b01;
    localparam logic [1:0] ST_BELOW  = 2'b10;
    localparam logic [1:0] ST_ABOVE  = 2'b11;

endpackage

// File: rtl/rd_latency_timer.sv
// BRAM read-latency timer: loaded when an address is issued; expire marks the
// final wait cycle, so read data is valid on the cycle after expire.
module rd_latency_timer #(
    parameter int BRAM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int CW = (BRAM_LAT > 2) ? $clog2(BRAM_LAT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(BRAM_LAT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == CW'(1));

endmodule

// File: rtl/lut_search_ctrl.sv
// Linear scan of the x,y-interleaved point table; exact hit or bracketing pair for the
// external interpolator. Define LUT_SEARCH_CLAMP_EN to return endpoint y out of range.
module lut_search_ctrl
    import lut_search_pkg::*;
#(
    parameter int DATA_W   = LUT_DATA_W,
    parameter int ADDR_W   = LUT_ADDR_W,
    parameter int BRAM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_x,
    input  logic [ADDR_W-2:0] n_points,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_x,
    input  logic [DATA_W-1:0] mem_y,
    output logic              interp_start,
    output logic [DATA_W-1:0] interp_x0,
    output logic [DATA_W-1:0] interp_y0,
    output logic [DATA_W-1:0] interp_x1,
    output logic [DATA_W-1:0] interp_y1,
    input  logic              interp_done,
    input  logic [DATA_W-1:0] interp_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic [1:0]        rsp_status
);

`ifdef LUT_SEARCH_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    lut_state_t        state, state_n;
    logic [DATA_W-1:0] x_lat, prev_x, prev_y;
    logic [ADDR_W-2:0] n_lat, k, k_inc;
    logic              rd_expire, hit, over, last;

    function automatic logic [DATA_W-1:0] out_of_range_y(input logic [DATA_W-1:0] y);
        return CLAMP_EN ? y : '0;
    endfunction

    assign k_inc     = k + 1'b1;
    assign hit       = (mem_x == x_lat);
    assign over      = (mem_x > x_lat);
    assign last      = (k_inc == n_lat);
    assign req_ready = (state == S_IDLE) && !reset;
    assign rsp_valid = (state == S_RESP);

    rd_latency_timer #(
        .BRAM_LAT (BRAM_LAT)
    ) u_rd_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (state == S_ISSUE),
        .expire (rd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (req_valid) state_n = S_ISSUE;
            S_ISSUE: begin
                if (n_lat == '0)        state_n = S_RESP;
                else if (BRAM_LAT == 1) state_n = S_COMPARE;
                else                    state_n = S_WAIT;
            end
            S_WAIT:    if (rd_expire) state_n = S_COMPARE;
            S_COMPARE: begin
                if (hit)                state_n = S_RESP;
                else if (over)          state_n = (k == '0) ? S_RESP : S_INTERP;
                else if (last)          state_n = S_RESP;
                else                    state_n = S_ISSUE;
            end
            S_INTERP:  if (interp_done) state_n = S_RESP;
            S_RESP:    if (rsp_ready) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Datapath: query latch, probe index, previous pair, operands and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_lat        <= '0;
            n_lat        <= '0;
            k            <= '0;
            prev_x       <= '0;
            prev_y       <= '0;
            mem_addr     <= '0;
            interp_start <= 1'b0;
            interp_x0    <= '0;
            interp_y0    <= '0;
            interp_x1    <= '0;
            interp_y1    <= '0;
            rsp_y        <= '0;
            rsp_status   <= ST_EXACT;
        end else begin
            interp_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        x_lat    <= req_x;
                        n_lat    <= n_points;
                        k        <= '0;
                        mem_addr <= '0;
                    end
                end
                S_ISSUE: begin
                    if (n_lat == '0) begin
                        rsp_y      <= '0;
                        rsp_status <= ST_ABOVE;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        rsp_y      <= mem_y;
                        rsp_status <= ST_EXACT;
                    end else if (over) begin
                        if (k == '0) begin
                            rsp_y      <= out_of_range_y(mem_y);
                            rsp_status <= ST_BELOW;
                        end else begin
                            interp_x0    <= prev_x;
                            interp_y0    <= prev_y;
                            interp_x1    <= mem_x;
                            interp_y1    <= mem_y;
                            interp_start <= 1'b1;
                        end
                    end else begin
                        prev_x <= mem_x;
                        prev_y <= mem_y;
                        if (last) begin
                            rsp_y      <= out_of_range_y(mem_y);
                            rsp_status <= ST_ABOVE;
                        end else begin
                            k        <= k_inc;
                            mem_addr <= {k_inc, 1'b0};
                        end
                    end
                end
                S_INTERP: begin
                    if (interp_done) begin
                        rsp_y      <= interp_y;
                        rsp_status <= ST_INTERP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
